loader_wb_bridge: RTL and testbench
===================================

Name: loader_wb_bridge

Overview:
- Sits between the HPS ioctl download port and the SDRAM wishbone slave.
- Buffers ROM/image download words in a small FIFO and writes them to SDRAM as single wishbone cycles, throttling the HPS through ioctl_wait.
- Arbitrates SDRAM ownership between the loader and the Archimedes core, handing the bus over only on wishbone cycle boundaries.

Parameters:
- FIFO_DEPTH, 4, download word FIFO entries (power of two, ≥2).
- WAIT_LEVEL, 2, FIFO occupancy at or above which ioctl_wait asserts.

Ports:
- clk_sys in 1: system clock (32 MHz domain); all logic on its rising edge.
- reset in 1: synchronous, active-high reset.
- ioctl_download in 1: HPS download active.
- ioctl_wr in 1: one-cycle strobe, download word valid.
- ioctl_addr in 25: download byte address; bits [23:2] used.
- ioctl_dout in 32: download data.
- ioctl_sel in 4: download byte enables.
- ioctl_wait out 1: back-pressure to the HPS.
- core_stb in 1: core wishbone strobe.
- core_cyc in 1: core wishbone cycle.
- core_we in 1: core write enable.
- core_sel in 4: core byte selects.
- core_adr in 22: core word address [23:2].
- core_dat_i in 32: core write data.
- core_ack out 1: ack returned to the core.
- ram_stb out 1: SDRAM wishbone strobe.
- ram_cyc out 1: SDRAM wishbone cycle.
- ram_we out 1: SDRAM write enable.
- ram_sel out 4: SDRAM byte selects.
- ram_adr out 26: SDRAM byte address {adr[23:2],2'b00}, upper bits 0.
- ram_dat_o out 32: SDRAM write data.
- ram_ack in 1: SDRAM acknowledge.
- loader_owns out 1: loader currently owns SDRAM; used to hold the core in reset.
- load_done out 1: one-cycle pulse when the loader releases the bus.
- word_count out 23: words written to SDRAM in the current/last download.
- overflow out 1: sticky; a strobe was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - FIFO empty; state CORE.
  - ioctl_wait=0, ram_stb=0, ram_cyc=0, ram_we=0, loader_owns=0, load_done=0, word_count=0, overflow=0.
  - Reset mid-transfer drops ram_stb/ram_cyc the next cycle and discards FIFO contents.
- FIFO:
  - ioctl_wr pushes {addr[23:2],sel,dout} regardless of state.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push while full with no pop is dropped and sets overflow. overflow clears only on reset or on an ioctl_download rising edge.
- ioctl_wait is registered: asserted when count ≥ WAIT_LEVEL, deasserted the cycle after count < WAIT_LEVEL.
- States:
  - CORE:
    - ram_* = core_* combinationally; core_ack = ram_ack.
    - On ioctl_download=1, go to HANDOVER.
  - HANDOVER:
    - Keep passing the core through until core_cyc=0, or until ram_ack completes the current core cycle.
    - Then register loader_owns=1, force core_ack=0, clear word_count and go to LOAD_IDLE.
    - This stops a partially acknowledged core access from being split.
  - LOAD_IDLE:
    - If FIFO not empty, register ram_stb=ram_cyc=ram_we=1 with the head entry and go to LOAD_WAIT. ram_stb rises one cycle after the FIFO goes non-empty.
    - Else if ioctl_download=0, go to RELEASE.
  - LOAD_WAIT:
    - Hold all ram_* stable until ram_ack.
    - On ram_ack: pop the FIFO, word_count+1 (saturates at all-ones), ram_stb=ram_cyc=0, return to LOAD_IDLE.
    - There is a minimum one idle cycle between loader cycles.
  - RELEASE:
    - loader_owns=0; load_done=1 for exactly one cycle; go to CORE the next cycle.
- ioctl_download falling while the FIFO is non-empty: all buffered words are written before RELEASE.
- ioctl_download re-rising during RELEASE: go through CORE, then HANDOVER again; no words are lost.
- ram_ack while ram_stb=0 in a loader state is ignored.
- core_ack=0 whenever loader_owns=1 or the state is not CORE/HANDOVER.

Test Plan:
- Reset hold 3 cycles, release -> all outputs 0, state CORE; core_stb=1, adr=0x000100 -> ram_adr=0x0000400, core_ack follows ram_ack.
- ioctl_download rises while a core read is pending, ram_ack 5 cycles later -> core_ack on that ack, loader_owns=1 the cycle after, no further core_ack.
- 8 back-to-back ioctl_wr (addr 0,4,…,28, data 0xA0..0xA7), ram_ack 3 cycles after each stb -> ioctl_wait asserts at count 2; ram writes in order with correct addr/data; word_count=8; overflow=0.
- Push into a full FIFO with ram_ack withheld -> overflow=1, entry dropped, word_count ends at FIFO_DEPTH.
- ioctl_download falls with 3 words queued -> 3 more ram writes, then load_done pulses once, loader_owns=0, core passthrough restored.
- Assert reset while ram_stb=1 -> ram_stb=0 the next cycle, FIFO empty, word_count=0.

Source files
------------

// File: rtl/loader_wb_bridge.sv
// rtl/loader_wb_bridge.sv - HPS download FIFO to SDRAM wishbone writer with core/loader bus arbitration
module loader_wb_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_LEVEL = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [31:0] ioctl_dout,
    input  logic [3:0]  ioctl_sel,
    output logic        ioctl_wait,
    input  logic        core_stb,
    input  logic        core_cyc,
    input  logic        core_we,
    input  logic [3:0]  core_sel,
    input  logic [21:0] core_adr,
    input  logic [31:0] core_dat_i,
    output logic        core_ack,
    output logic        ram_stb,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [25:0] ram_adr,
    output logic [31:0] ram_dat_o,
    input  logic        ram_ack,
    output logic        loader_owns,
    output logic        load_done,
    output logic [22:0] word_count,
    output logic        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 22 + 4 + 32;

    typedef enum logic [2:0] {
        S_CORE,
        S_HANDOVER,
        S_LOAD_IDLE,
        S_LOAD_WAIT,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wait_q, wait_d;
    logic            stb_q, stb_d, cyc_q, cyc_d, we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [21:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            owns_q, owns_d;
    logic            done_q, done_d;
    logic [22:0]     wc_q, wc_d;
    logic            ovf_q, ovf_d;
    logic            dl_q, dl_d;

    logic            push, pop, full, pass;
    logic [EW-1:0]   head;
    logic            unused_addr_bits;

    assign unused_addr_bits = &{1'b0, ioctl_addr[24], ioctl_addr[1:0]};

    // FIFO bookkeeping, back-pressure, overflow tracking and download edge detect
    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = (state_q == S_LOAD_WAIT) && stb_q && ram_ack;
        push     = ioctl_wr && (!full || pop);
        head     = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ioctl_addr[23:2], ioctl_sel, ioctl_dout};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        wait_d = (count_d >= CW'(WAIT_LEVEL));
        dl_d   = ioctl_download;
        ovf_d  = ovf_q;
        if (ioctl_download && !dl_q) begin
            ovf_d = 1'b0;
        end
        if (ioctl_wr && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Ownership FSM: next state and registered loader-side bus signals
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        owns_d  = owns_q;
        done_d  = 1'b0;
        wc_d    = wc_q;
        case (state_q)
            S_CORE: begin
                if (ioctl_download) begin
                    state_d = S_HANDOVER;
                end
            end
            S_HANDOVER: begin
                // Wait for the core cycle to end so an access is never split
                if (!core_cyc || ram_ack) begin
                    owns_d  = 1'b1;
                    wc_d    = '0;
                    state_d = S_LOAD_IDLE;
                end
            end
            S_LOAD_IDLE: begin
                if (count_q != '0) begin
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = head[57:36];
                    sel_d   = head[35:32];
                    dat_d   = head[31:0];
                    state_d = S_LOAD_WAIT;
                end else if (!ioctl_download) begin
                    owns_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_LOAD_WAIT: begin
                if (pop) begin
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    wc_d    = (&wc_q) ? wc_q : wc_q + 23'd1;
                    state_d = S_LOAD_IDLE;
                end
            end
            S_RELEASE: begin
                state_d = S_CORE;
            end
            default: begin
                state_d = S_CORE;
            end
        endcase
    end

    // Bus mux: core passes straight through until the loader takes over
    always_comb begin
        pass      = (state_q == S_CORE) || (state_q == S_HANDOVER);
        ram_stb   = pass ? core_stb : stb_q;
        ram_cyc   = pass ? core_cyc : cyc_q;
        ram_we    = pass ? core_we : we_q;
        ram_sel   = pass ? core_sel : sel_q;
        ram_adr   = pass ? {2'b00, core_adr, 2'b00} : {2'b00, adr_q, 2'b00};
        ram_dat_o = pass ? core_dat_i : dat_q;
        core_ack  = pass && !owns_q && ram_ack;
    end

    assign ioctl_wait  = wait_q;
    assign loader_owns = owns_q;
    assign load_done   = done_q;
    assign word_count  = wc_q;
    assign overflow    = ovf_q;

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_CORE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= 1'b0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            owns_q   <= 1'b0;
            done_q   <= 1'b0;
            wc_q     <= '0;
            ovf_q    <= 1'b0;
            dl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            owns_q   <= owns_d;
            done_q   <= done_d;
            wc_q     <= wc_d;
            ovf_q    <= ovf_d;
            dl_q     <= dl_d;
        end
    end
endmodule

// File: tb/tb_loader_wb_bridge.sv
// tb/tb_loader_wb_bridge.sv - self-checking bench for loader_wb_bridge
module tb_loader_wb_bridge;
    localparam int DEPTH = 4;
    localparam int WL    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [24:0] ioctl_addr;
    logic [31:0] ioctl_dout;
    logic [3:0]  ioctl_sel;
    logic        core_stb, core_cyc, core_we, core_ack;
    logic [3:0]  core_sel;
    logic [21:0] core_adr;
    logic [31:0] core_dat_i;
    logic        ram_stb, ram_cyc, ram_we, ram_ack;
    logic [3:0]  ram_sel;
    logic [25:0] ram_adr;
    logic [31:0] ram_dat_o;
    logic        loader_owns, load_done, overflow;
    logic [22:0] word_count;

    always #5 clk = ~clk;

    loader_wb_bridge #(.FIFO_DEPTH(DEPTH), .WAIT_LEVEL(WL)) dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_sel(ioctl_sel), .ioctl_wait(ioctl_wait),
        .core_stb(core_stb), .core_cyc(core_cyc), .core_we(core_we), .core_sel(core_sel),
        .core_adr(core_adr), .core_dat_i(core_dat_i), .core_ack(core_ack),
        .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_adr(ram_adr), .ram_dat_o(ram_dat_o), .ram_ack(ram_ack),
        .loader_owns(loader_owns), .load_done(load_done),
        .word_count(word_count), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Model: queue of accepted download words, counts and sticky flag
    typedef struct packed {
        logic [21:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq[$];
    int          m_wc = 0;
    logic        m_ovf = 1'b0;
    logic        m_prev_dl = 1'b0;
    logic        m_prev_owns = 1'b0;
    logic        m_pop;
    int          n_done = 0;
    logic        seen_wait = 1'b0;
    logic [25:0] last_adr = '0;
    logic [31:0] last_dat = '0;
    bit          chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (loader_owns && !m_prev_owns) m_wc = 0;
            check("ioctl_wait", ioctl_wait, 64'(mq.size() >= WL));
            check("overflow", overflow, m_ovf);
            if (loader_owns) begin
                check("core_ack_blocked", core_ack, 0);
                check("word_count", word_count, m_wc);
                if (ram_stb) begin
                    check("ram_stb_needs_data", ram_stb, 64'(mq.size() != 0));
                    if (mq.size() != 0) begin
                        check("ld_ram_adr", ram_adr, {2'b00, mq[0].adr, 2'b00});
                        check("ld_ram_dat", ram_dat_o, mq[0].dat);
                        check("ld_ram_sel", ram_sel, mq[0].sel);
                        check("ld_ram_we", ram_we, 1);
                        check("ld_ram_cyc", ram_cyc, 1);
                    end
                end
            end else if (!load_done) begin
                check("pt_stb", ram_stb, core_stb);
                check("pt_cyc", ram_cyc, core_cyc);
                check("pt_we", ram_we, core_we);
                check("pt_sel", ram_sel, core_sel);
                check("pt_adr", ram_adr, {2'b00, core_adr, 2'b00});
                check("pt_dat", ram_dat_o, core_dat_i);
                check("pt_ack", core_ack, ram_ack);
            end
            if (load_done) n_done++;
            if (ioctl_wait) seen_wait = 1'b1;
            m_pop = loader_owns && ram_stb && ram_ack && (mq.size() != 0);
            if (reset) begin
                mq.delete();
                m_wc = 0;
                m_ovf = 1'b0;
                m_prev_dl = 1'b0;
            end else begin
                if (ioctl_download && !m_prev_dl) m_ovf = 1'b0;
                if (m_pop) begin
                    last_adr = {2'b00, mq[0].adr, 2'b00};
                    last_dat = mq[0].dat;
                    void'(mq.pop_front());
                    m_wc++;
                end
                if (ioctl_wr) begin
                    if (mq.size() < DEPTH) mq.push_back({ioctl_addr[23:2], ioctl_sel, ioctl_dout});
                    else m_ovf = 1'b1;
                end
                m_prev_dl = ioctl_download;
            end
            m_prev_owns = loader_owns;
        end
    end

    // SDRAM responder: auto-ack loader cycles after ack_delay, or manual ack
    bit ack_auto = 1'b0;
    int ack_delay = 3;
    bit manual_ack = 1'b0;
    bit auto_pulse = 1'b0;
    int wcnt = 0;

    initial begin
        ram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_pulse) begin
                auto_pulse = 1'b0;
            end else if (ack_auto && loader_owns && ram_stb) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    auto_pulse = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
            ram_ack = auto_pulse | manual_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int d0;

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_sel = 4'hF;
        core_stb = 1'b0; core_cyc = 1'b0; core_we = 1'b0; core_sel = 4'hF;
        core_adr = '0; core_dat_i = '0;
        repeat (3) tick();
        sample();
        check("rst_ioctl_wait", ioctl_wait, 0);
        check("rst_ram_stb", ram_stb, 0);
        check("rst_ram_cyc", ram_cyc, 0);
        check("rst_loader_owns", loader_owns, 0);
        check("rst_load_done", load_done, 0);
        check("rst_word_count", word_count, 0);
        check("rst_overflow", overflow, 0);
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Core passthrough
        core_cyc = 1'b1; core_stb = 1'b1; core_adr = 22'h000100;
        tick(); sample();
        check("t1_ram_adr", ram_adr, 26'h0000400);
        check("t1_ram_stb", ram_stb, 1);
        tick(); manual_ack = 1'b1; sample();
        check("t1_core_ack", core_ack, 1);
        tick(); manual_ack = 1'b0; core_cyc = 1'b0; core_stb = 1'b0; sample();
        check("t1_core_ack_low", core_ack, 0);

        // Handover waits for the pending core cycle
        tick(); core_cyc = 1'b1; core_stb = 1'b1; core_adr = 22'h000055;
        tick(); ioctl_download = 1'b1;
        repeat (4) tick();
        manual_ack = 1'b1; sample();
        check("t2_core_ack", core_ack, 1);
        check("t2_owns_before", loader_owns, 0);
        tick(); manual_ack = 1'b0; core_cyc = 1'b0; core_stb = 1'b0; sample();
        check("t2_owns_after", loader_owns, 1);
        check("t2_core_ack_off", core_ack, 0);

        // Eight words, HPS honouring ioctl_wait
        ack_auto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 100 && ioctl_wait; k++) tick();
            ioctl_addr = 25'(i * 4); ioctl_dout = 32'(32'hA0 + i); ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
        end
        for (int k = 0; k < 300 && word_count != 23'd8; k++) tick();
        sample();
        check("t3_word_count", word_count, 8);
        check("t3_overflow", overflow, 0);
        check("t3_seen_wait", seen_wait, 1);
        check("t3_last_adr", last_adr, 26'h000001C);
        check("t3_last_dat", last_dat, 32'hA7);

        // Download ends with 3 words queued
        tick(); ack_auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 25'(32'h40 + i * 4); ioctl_dout = 32'(32'hC0 + i); ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
        end
        ioctl_download = 1'b0;
        d0 = n_done;
        ack_auto = 1'b1;
        for (int k = 0; k < 300 && !load_done; k++) tick();
        sample();
        check("t5_load_done", load_done, 1);
        check("t5_owns", loader_owns, 0);
        check("t5_word_count", word_count, 11);
        check("t5_last_dat", last_dat, 32'hC2);
        tick(); tick(); sample();
        check("t5_done_once", n_done - d0, 1);
        check("t5_done_low", load_done, 0);
        tick(); core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b1;
        core_adr = 22'h3FFFFF; core_dat_i = 32'hDEADBEEF;
        sample();
        check("t5_pt_adr", ram_adr, 26'h0FFFFFC);
        check("t5_pt_dat", ram_dat_o, 32'hDEADBEEF);
        tick(); manual_ack = 1'b1; sample();
        check("t5_pt_ack", core_ack, 1);
        tick(); manual_ack = 1'b0; core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0;

        // Overflow on a fresh download
        ioctl_download = 1'b1;
        repeat (3) tick(); sample();
        check("t4_owns", loader_owns, 1);
        check("t4_wc_cleared", word_count, 0);
        tick(); ack_auto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ioctl_addr = 25'(32'h80 + i * 4); ioctl_dout = 32'(32'hB0 + i); ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
        end
        sample();
        check("t4_overflow", overflow, 1);
        tick(); ack_auto = 1'b1;
        for (int k = 0; k < 300 && word_count != 23'd4; k++) tick();
        repeat (10) tick(); sample();
        check("t4_word_count", word_count, DEPTH);
        check("t4_last_dat", last_dat, 32'hB3);
        check("t4_overflow_sticky", overflow, 1);

        // Reset while a loader cycle is outstanding
        tick(); ack_auto = 1'b0;
        ioctl_addr = 25'h200; ioctl_dout = 32'h11; ioctl_wr = 1'b1;
        tick(); ioctl_wr = 1'b0;
        for (int k = 0; k < 20 && !ram_stb; k++) tick();
        sample();
        check("t6_stb_before", ram_stb, 1);
        tick(); reset = 1'b1;
        tick(); sample();
        check("t6_stb_after", ram_stb, 0);
        check("t6_word_count", word_count, 0);
        check("t6_owns", loader_owns, 0);
        check("t6_overflow", overflow, 0);
        check("t6_wait", ioctl_wait, 0);
        tick(); reset = 1'b0; ack_auto = 1'b1;
        repeat (12) tick(); sample();
        check("t6_fifo_discarded", word_count, 0);
        check("t6_reowned", loader_owns, 1);

        tick(); ioctl_download = 1'b0;
        for (int k = 0; k < 50 && !load_done; k++) tick();
        sample();
        check("end_load_done", load_done, 1);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
